flatten_buffer: RTL and testbench

- Sits directly downstream of the two-layer conv/pooling stage.
- Captures that stage's per-kernel pooled feature maps, which arrive on ProcessingElements parallel lanes with one valid bit per kernel, into an internal word array.
- Once a full set is captured, streams the flattened vector out one word per beat, kernel-major, over a valid/ready handshake into the dense/classifier stage.
- Memory entries are cleared as they are read, so an incomplete set drains with zeros in the missing positions.

---
 rtl/flatten_buffer.sv | 162 ++++++++++++++++
 tb/tb_flatten_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/flatten_buffer.sv
// Captures per-kernel pooled feature maps from parallel lanes and streams
// them out kernel-major over valid/ready; entries are cleared as they drain.
module flatten_buffer #(
  parameter int BitSize            = 32,
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int MapWidth           = 2
) (
  input  logic                                         clk,
  input  logic                                         res,
  input  logic [NumberOfK-1:0]                         in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
  input  logic                                         in_set_done,
  output logic                                         in_ready,
  output logic                                         out_valid,
  output logic [BitSize-1:0]                           out_data,
  output logic                                         out_last,
  input  logic                                         out_ready,
  output logic                                         err_overflow,
  output logic                                         err_underflow
);

  localparam int MAP_SIZE = MapWidth * MapWidth;
  localparam int DEPTH    = NumberOfK * MAP_SIZE;
  localparam int WCW      = $clog2(MAP_SIZE + 1);
  localparam int PW       = $clog2(DEPTH);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [BitSize-1:0]       mem_r      [DEPTH];
  logic [WCW-1:0]           wc_r       [NumberOfK];
  logic [WCW-1:0]           wc_next_s  [NumberOfK];
  logic [PW-1:0]            wr_addr_s  [NumberOfK];
  logic [PW-1:0]            rd_ptr_r;
  logic [NumberOfK-1:0]     accept_s;
  logic [NumberOfK-1:0]     drop_s;
  logic [ProcessingElements-1:0] lane_taken_s;
  logic                     all_full_s;
  logic                     rd_fire_s;
  logic                     rd_last_s;
  logic                     err_overflow_r;
  logic                     err_underflow_r;

  // Write arbitration: lowest kernel wins its lane; full or losing kernels drop.
  always_comb begin
    lane_taken_s = '0;
    accept_s     = '0;
    drop_s       = '0;
    all_full_s   = 1'b1;
    for (int k = 0; k < NumberOfK; k++) begin
      wc_next_s[k] = wc_r[k];
      wr_addr_s[k] = PW'(k * MAP_SIZE) + PW'(wc_r[k]);
      if (state_r == FILL && in_valid[k] && wc_r[k] < WCW'(MAP_SIZE) &&
          !lane_taken_s[k % ProcessingElements]) begin
        accept_s[k]                           = 1'b1;
        lane_taken_s[k % ProcessingElements]  = 1'b1;
        wc_next_s[k]                          = wc_r[k] + WCW'(1);
      end else begin
        drop_s[k] = in_valid[k];
      end
      if (wc_next_s[k] != WCW'(MAP_SIZE)) begin
        all_full_s = 1'b0;
      end else begin
        all_full_s = all_full_s;
      end
    end
  end

  assign rd_fire_s = (state_r == DRAIN) && out_ready;
  assign rd_last_s = (rd_ptr_r == PW'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: completion or set_done ends FILL; last handshake ends DRAIN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (all_full_s || in_set_done) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FILL;
        end
      end
      DRAIN: begin
        if (rd_fire_s && rd_last_s) begin
          state_next_s = FILL;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = FILL;
    endcase
  end

  // Memory, counters, read pointer and sticky error flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      for (int k = 0; k < NumberOfK; k++) begin
        wc_r[k] <= '0;
      end
      rd_ptr_r        <= '0;
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      for (int k = 0; k < NumberOfK; k++) begin
        if (accept_s[k]) begin
          mem_r[wr_addr_s[k]] <= in_data[k % ProcessingElements];
        end
      end
      if (rd_fire_s) begin
        mem_r[rd_ptr_r] <= '0;
      end
      if (rd_fire_s && rd_last_s) begin
        for (int k = 0; k < NumberOfK; k++) begin
          wc_r[k] <= '0;
        end
        rd_ptr_r <= '0;
      end else begin
        for (int k = 0; k < NumberOfK; k++) begin
          wc_r[k] <= wc_next_s[k];
        end
        if (rd_fire_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
      end
      err_overflow_r  <= err_overflow_r | (|drop_s);
      err_underflow_r <= err_underflow_r |
                         ((state_r == FILL) && in_set_done && !all_full_s);
    end
  end

  // Output decode; out_data is forced to zero outside DRAIN.
  always_comb begin
    in_ready      = (state_r == FILL);
    out_valid     = (state_r == DRAIN);
    out_last      = (state_r == DRAIN) && rd_last_s;
    err_overflow  = err_overflow_r;
    err_underflow = err_underflow_r;
    if (state_r == DRAIN) begin
      out_data = mem_r[rd_ptr_r];
    end else begin
      out_data = '0;
    end
  end

endmodule

// File: tb/tb_flatten_buffer.sv
// Directed bench for flatten_buffer: full frame, backpressure, early end,
// overflow, lane conflict and asynchronous reset during drain.
module tb_flatten_buffer;

  logic              clk = 1'b0;
  logic              res;
  logic [3:0]        in_valid;
  logic [1:0][31:0]  in_data;
  logic              in_set_done;
  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_last;
  logic              out_ready;
  logic              err_overflow;
  logic              err_underflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_r [16];

  flatten_buffer dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_set_done(in_set_done), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1; in_valid = '0; in_data = '0; in_set_done = 1'b0; out_ready = 1'b0;
    tick();
    res = 1'b0;
  endtask

  // Pixels 0..npix-1 of every kernel: kernels 0/1 then kernels 2/3 per pixel.
  task automatic send_frame(input int npix);
    for (int p = 0; p < npix; p++) begin
      in_valid = 4'b0011; in_data[0] = 32'(p); in_data[1] = 32'(16 + p);
      chk("fill_no_valid_a", out_valid, 1'b0);
      tick();
      in_valid = 4'b1100; in_data[0] = 32'(32 + p); in_data[1] = 32'(48 + p);
      chk("fill_no_valid_b", out_valid, 1'b0);
      tick();
    end
    in_valid = '0;
  endtask

  task automatic set_expect(input int npix);
    for (int i = 0; i < 16; i++) begin
      exp_r[i] = ((i % 4) < npix) ? 32'((i / 4) * 16 + (i % 4)) : 32'd0;
    end
  endtask

  task automatic set_done_pulse();
    in_set_done = 1'b1;
    tick();
    in_set_done = 1'b0;
  endtask

  // Collect n words; bp selects out_ready pattern 1,0,0,1,0,0...
  task automatic drain(input int n, input bit bp);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    while (idx < n && cyc < 200) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (stalled) begin
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("word%0d", idx), out_data, exp_r[idx]);
        chk($sformatf("last%0d", idx), out_last, (idx == 15));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        pd = out_data;
        pl = out_last;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", idx, n);
    if (n == 16) begin
      chk("post_in_ready", in_ready, 1'b1);
      chk("post_out_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_ovf", err_overflow, 1'b0);
    chk("rst_unf", err_underflow, 1'b0);

    // Full frame, no backpressure
    send_frame(4);
    chk("full_valid_rise", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    set_expect(4);
    drain(16, 1'b0);
    chk("full_ovf", err_overflow, 1'b0);
    chk("full_unf", err_underflow, 1'b0);

    // Backpressure
    send_frame(4);
    drain(16, 1'b1);

    // Early set end, then a full frame confirms read-clear
    send_frame(2);
    chk("early_not_valid", out_valid, 1'b0);
    set_done_pulse();
    chk("early_unf", err_underflow, 1'b1);
    chk("early_valid", out_valid, 1'b1);
    set_expect(2);
    drain(16, 1'b0);
    send_frame(4);
    set_expect(4);
    drain(16, 1'b0);

    // Overflow during DRAIN
    do_reset();
    send_frame(4);
    in_valid = 4'b0001; in_data[0] = 32'd99;
    tick();
    in_valid = '0;
    chk("drain_ovf", err_overflow, 1'b1);
    set_expect(4);
    drain(16, 1'b0);

    // Fifth pixel to kernel 0 in FILL
    do_reset();
    for (int p = 0; p < 5; p++) begin
      in_valid = 4'b0001; in_data[0] = 32'(100 + p);
      tick();
    end
    in_valid = '0;
    chk("fill_ovf", err_overflow, 1'b1);
    set_done_pulse();
    for (int i = 0; i < 16; i++) exp_r[i] = (i < 4) ? 32'(100 + i) : 32'd0;
    drain(16, 1'b0);

    // Lane conflict: kernels 0 and 2 share lane 0
    do_reset();
    in_valid = 4'b0101; in_data[0] = 32'd7;
    tick();
    in_valid = '0;
    chk("conf_ovf", err_overflow, 1'b1);
    set_done_pulse();
    for (int i = 0; i < 16; i++) exp_r[i] = (i == 0) ? 32'd7 : 32'd0;
    drain(16, 1'b0);

    // Reset mid-drain after five words
    do_reset();
    send_frame(4);
    set_expect(4);
    drain(5, 1'b0);
    res = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    res = 1'b0;
    tick();
    set_done_pulse();
    for (int i = 0; i < 16; i++) exp_r[i] = 32'd0;
    drain(16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
